pc_sequencer: RTL

Registered program-counter sequencer for the single-issue CPU. Each cycle it advances, holds or redirects the PC using the pipeline stall and the taken-branch/jump decision from the branch-resolution logic. It drives the fetch address, and after a redirect it raises a fixed-length flush window so younger wrong-path instructions are squashed. It also provides a terminal halt state.

---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/pc_seq_sat_counter.sv | 31 +++
 rtl/pc_sequencer.sv | 119 +++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the PC sequencer: FSM state encoding,
// flush-window counter width and performance-counter width.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    PC_SEQ_RUN   = 2'd0,
    PC_SEQ_FLUSH = 2'd1,
    PC_SEQ_HALT  = 2'd2
  } pc_seq_state_e;

  localparam int FLUSH_CNT_W = 3;
  localparam int PERF_CNT_W  = 16;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the pipeline control logic (master) and
// the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                in_redirect;
  logic [PC_WIDTH-1:0] in_target;
  logic                in_stall;
  logic                in_halt;
  logic [PC_WIDTH-1:0] out_pc;
  logic                out_pc_valid;
  logic                out_flush;
  logic                out_halted;

  modport master (
    output in_redirect, in_target, in_stall, in_halt,
    input  out_pc, out_pc_valid, out_flush, out_halted
  );

  modport slave (
    input  in_redirect, in_target, in_stall, in_halt,
    output out_pc, out_pc_valid, out_flush, out_halted
  );
endinterface

// File: rtl/pc_seq_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at
// all-ones once reached.
module pc_seq_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: RUN / FLUSH / HALT FSM driving the
// fetch address. Define PC_SEQ_PERF_EN to add redirect and stall counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  PC_STEP      = 1,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  pc_sequencer_if.slave         bus
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] out_redirect_cnt,
  output logic [PERF_CNT_W-1:0] out_stall_cnt
`endif
);

  pc_seq_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   flush_q, flush_d;
  logic                   halted_q, halted_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      PC_SEQ_RUN: begin
        if (bus.in_halt) begin
          state_d = PC_SEQ_HALT;
        end else if (bus.in_redirect) begin
          state_d = PC_SEQ_FLUSH;
          pc_d    = bus.in_target;
          cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
        end else if (!bus.in_stall) begin
          pc_d = pc_q + PC_WIDTH'(PC_STEP);
        end
      end
      // Stall does not stretch the window; the PC sits on the target throughout.
      PC_SEQ_FLUSH: begin
        if (bus.in_halt) begin
          state_d = PC_SEQ_HALT;
        end else if (bus.in_redirect) begin
          pc_d  = bus.in_target;
          cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = PC_SEQ_RUN;
        end else begin
          cnt_d = cnt_q - FLUSH_CNT_W'(1);
        end
      end
      PC_SEQ_HALT: begin
        state_d = PC_SEQ_HALT;
      end
      default: begin
        state_d = PC_SEQ_RUN;
      end
    endcase
  end

  // Status flags are registered from the next state so they align with out_pc.
  always_comb begin
    valid_d  = (state_d == PC_SEQ_RUN);
    flush_d  = (state_d == PC_SEQ_FLUSH);
    halted_d = (state_d == PC_SEQ_HALT);
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_q  <= PC_SEQ_RUN;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      valid_q  <= 1'b1;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
    end
  end

  assign bus.out_pc       = pc_q;
  assign bus.out_pc_valid = valid_q;
  assign bus.out_flush    = flush_q;
  assign bus.out_halted   = halted_q;

`ifdef PC_SEQ_PERF_EN
  logic redirect_acc;
  logic stall_acc;

  assign redirect_acc = (state_q != PC_SEQ_HALT) && !bus.in_halt && bus.in_redirect;
  assign stall_acc    = (state_q == PC_SEQ_RUN) && !bus.in_halt && !bus.in_redirect
                        && bus.in_stall;

  pc_seq_sat_counter #(.WIDTH(PERF_CNT_W)) u_redirect_cnt (
    .clk_i   (in_clk),
    .rst_n_i (in_rst_n),
    .inc_i   (redirect_acc),
    .cnt_o   (out_redirect_cnt)
  );

  pc_seq_sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk_i   (in_clk),
    .rst_n_i (in_rst_n),
    .inc_i   (stall_acc),
    .cnt_o   (out_stall_cnt)
  );
`endif

endmodule
